// File: rtl/sumador_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package sumador_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/sumador_digito.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module sumador_digito #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    c        = ci;
    s        = '0;
    c_msb_in = ci;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/sumador_serial_n.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock.
module sumador_serial_n
  import sumador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co, dig_cmsb, last;

  assign last = (cnt_q == CW'(N - 1));

  sumador_digito #(.DIGIT(DIGIT)) u_digito (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .ci       (c_q),
    .s        (dig_s),
    .co       (dig_co),
    .c_msb_in (dig_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = A;
          // Subtraction runs as A + ~B + ~cin through the same adder.
          b_d     = (sub == MODE_SUB) ? ~B : B;
          c_d     = (sub == MODE_SUB) ? ~cin : cin;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = dig_co;
        r_d   = (r_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          s_d     = r_d;
          cout_d  = dig_co;
          ovf_d   = dig_cmsb ^ dig_co;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sumador_serial_n.sv
// Scoreboard bench: four configurations (3/1, 8/2, 8/1, 4/4) driven with directed vectors.
module tb_sumador_serial_n;

  typedef struct {
    int         idx;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a   [4];
  logic       start_a [4];
  logic       sub_a   [4];
  logic       cin_a   [4];
  logic [7:0] A_a     [4];
  logic [7:0] B_a     [4];
  logic       busy_w  [4];
  logic       done_w  [4];
  logic       cout_w  [4];
  logic       ovf_w   [4];
  logic [2:0] s0;
  logic [7:0] s1, s2;
  logic [3:0] s3;

  exp_t sbq[$];
  exp_t e;
  int   cyc = 0;
  int   bcnt[4];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sumador_serial_n #(.WIDTH(3), .DIGIT(1)) dut0 (
    .clk(clk), .rst_n(rst_a[0]), .start(start_a[0]), .sub(sub_a[0]),
    .A(A_a[0][2:0]), .B(B_a[0][2:0]), .cin(cin_a[0]), .busy(busy_w[0]),
    .done(done_w[0]), .S(s0), .Cout(cout_w[0]), .ovf(ovf_w[0]));
  sumador_serial_n #(.WIDTH(8), .DIGIT(2)) dut1 (
    .clk(clk), .rst_n(rst_a[1]), .start(start_a[1]), .sub(sub_a[1]),
    .A(A_a[1]), .B(B_a[1]), .cin(cin_a[1]), .busy(busy_w[1]),
    .done(done_w[1]), .S(s1), .Cout(cout_w[1]), .ovf(ovf_w[1]));
  sumador_serial_n #(.WIDTH(8), .DIGIT(1)) dut2 (
    .clk(clk), .rst_n(rst_a[2]), .start(start_a[2]), .sub(sub_a[2]),
    .A(A_a[2]), .B(B_a[2]), .cin(cin_a[2]), .busy(busy_w[2]),
    .done(done_w[2]), .S(s2), .Cout(cout_w[2]), .ovf(ovf_w[2]));
  sumador_serial_n #(.WIDTH(4), .DIGIT(4)) dut3 (
    .clk(clk), .rst_n(rst_a[3]), .start(start_a[3]), .sub(sub_a[3]),
    .A(A_a[3][3:0]), .B(B_a[3][3:0]), .cin(cin_a[3]), .busy(busy_w[3]),
    .done(done_w[3]), .S(s3), .Cout(cout_w[3]), .ovf(ovf_w[3]));

  function automatic logic [7:0] get_s(input int i);
    case (i)
      0:       return {5'b0, s0};
      1:       return s1;
      2:       return s2;
      default: return {4'b0, s3};
    endcase
  endfunction

  function automatic int n_of(input int i);
    case (i)
      0:       return 3;
      1:       return 4;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, i, act, exp);
    end
  endtask

  task automatic chk_zero(input int i);
    chk("rst_S", i, get_s(i), 0);
    chk("rst_Cout", i, cout_w[i], 0);
    chk("rst_ovf", i, ovf_w[i], 0);
    chk("rst_busy", i, busy_w[i], 0);
    chk("rst_done", i, done_w[i], 0);
  endtask

  task automatic wait_idle(input int i);
    int k = 0;
    while (busy_w[i] && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (k >= 64) chk("idle_timeout", i, busy_w[i], 0);
  endtask

  task automatic issue(input int i, input logic sb, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    start_a[i] = 1'b1; sub_a[i] = sb; A_a[i] = a; B_a[i] = b; cin_a[i] = c;
    @(posedge clk);
    #1;
    sbq.push_back('{idx: i, s: es, cout: ec, ovf: eo, acc: cyc});
    start_a[i] = 1'b0;
    wait_idle(i);
  endtask

  // Monitor: pops the scoreboard whenever any instance signals done.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_a[i]) begin
        bcnt[i] = 0;
      end else begin
        if (busy_w[i]) bcnt[i]++;
        if (done_w[i]) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", i, 0, 1);
          end else begin
            e = sbq.pop_front();
            chk("dut_index", i, i, e.idx);
            chk("S", i, get_s(i), e.s);
            chk("Cout", i, cout_w[i], e.cout);
            chk("ovf", i, ovf_w[i], e.ovf);
            chk("latency", i, cyc - e.acc, n_of(i));
            chk("busy_cycles", i, bcnt[i], n_of(i));
          end
          bcnt[i] = 0;
        end
      end
    end
  end

  initial begin
    int         acc1;
    logic [2:0] av, bv;
    logic [3:0] sum;
    for (int i = 0; i < 4; i++) begin
      rst_a[i] = 1'b1; start_a[i] = 1'b0; sub_a[i] = 1'b0; cin_a[i] = 1'b0;
      A_a[i] = '0; B_a[i] = '0; bcnt[i] = 0;
    end
    #1;
    for (int i = 0; i < 4; i++) rst_a[i] = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk_zero(i);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) rst_a[i] = 1'b1;

    // WIDTH=3 full sweep, add, cin=0
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        av  = 3'(a);
        bv  = 3'(b);
        sum = {1'b0, av} + {1'b0, bv};
        issue(0, 1'b0, {5'b0, av}, {5'b0, bv}, 1'b0, {5'b0, sum[2:0]}, sum[3],
              (av[2] == bv[2]) && (sum[2] != av[2]));
      end
    end

    // WIDTH=8 DIGIT=2 add overflow
    issue(1, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    issue(1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

    // WIDTH=8 DIGIT=1 subtract
    issue(2, 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    issue(2, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Single-cycle configuration
    issue(3, 1'b0, 8'h09, 8'h08, 1'b1, 8'h02, 1'b1, 1'b1);
    issue(3, 1'b1, 8'h03, 8'h05, 1'b0, 8'h0E, 1'b0, 1'b0);

    // start held high: second accept at acc1+N+1
    @(negedge clk);
    start_a[2] = 1'b1; sub_a[2] = 1'b0; A_a[2] = 8'h10; B_a[2] = 8'h20; cin_a[2] = 1'b0;
    @(posedge clk);
    #1;
    acc1 = cyc;
    sbq.push_back('{idx: 2, s: 8'h30, cout: 1'b0, ovf: 1'b0, acc: acc1});
    sbq.push_back('{idx: 2, s: 8'h10, cout: 1'b1, ovf: 1'b0, acc: acc1 + 9});
    @(negedge clk);
    A_a[2] = 8'hF0;
    while (cyc < acc1 + 9) @(negedge clk);
    start_a[2] = 1'b0;
    wait_idle(2);

    // start pulse and operand churn mid-RUN must not disturb the operation
    @(negedge clk);
    start_a[2] = 1'b1; sub_a[2] = 1'b0; A_a[2] = 8'h12; B_a[2] = 8'h34;
    @(posedge clk);
    #1;
    sbq.push_back('{idx: 2, s: 8'h46, cout: 1'b0, ovf: 1'b0, acc: cyc});
    start_a[2] = 1'b0;
    repeat (3) @(negedge clk);
    start_a[2] = 1'b1; sub_a[2] = 1'b1; A_a[2] = 8'hFF; B_a[2] = 8'hFF; cin_a[2] = 1'b1;
    @(negedge clk);
    start_a[2] = 1'b0;
    wait_idle(2);

    // Reset two cycles into an operation: aborts with no done
    @(negedge clk);
    start_a[2] = 1'b1; sub_a[2] = 1'b1; A_a[2] = 8'h80; B_a[2] = 8'h01; cin_a[2] = 1'b0;
    @(posedge clk);
    #1;
    start_a[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_a[2] = 1'b0;
    #1;
    chk_zero(2);
    repeat (10) @(negedge clk);
    rst_a[2] = 1'b1;
    issue(2, 1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 0, sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
